norm_feeder: RTL and testbench

Streaming source for the normalization block. On a start request it reads DESIGN_SIZE consecutive matmul-result columns from the output block RAM, with base/stride addressing. It drives them into the normalization block's `in_data_available`/`inp_data` input as one unbroken burst, one column per clock. It also holds the `mean`, `inv_var` and `validity_mask` operands stable for the whole operation and reports completion only after the normalization block raises `done_norm`.

---
 rtl/norm_feeder.sv | 168 ++++++++++++++++
 tb/tb_norm_feeder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/norm_feeder.sv
// Streams DESIGN_SIZE result columns from the output RAM into the normalization block as one
// unbroken burst and holds its operands. Optional lane zero-padding: NORM_FEEDER_ZERO_PAD_EN.
module norm_feeder #(
    parameter int DWIDTH            = 8,
    parameter int DESIGN_SIZE       = 32,
    parameter int AWIDTH            = 10,
    parameter int ADDR_STRIDE_WIDTH = 16,
    parameter int MASK_WIDTH        = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [AWIDTH-1:0]             base_addr,
    input  logic [ADDR_STRIDE_WIDTH-1:0]  addr_stride,
    input  logic [DWIDTH-1:0]             mean_in,
    input  logic [DWIDTH-1:0]             inv_var_in,
    input  logic [MASK_WIDTH-1:0]         mask_in,
    output logic                          ram_en,
    output logic [AWIDTH-1:0]             ram_addr,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] ram_rdata,
    output logic                          out_data_available,
    output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
    output logic [DWIDTH-1:0]             mean,
    output logic [DWIDTH-1:0]             inv_var,
    output logic [MASK_WIDTH-1:0]         validity_mask,
    input  logic                          done_norm,
    output logic                          done_feed
);

    localparam int LOG2_DESIGN_SIZE = $clog2(DESIGN_SIZE);
    localparam int CW    = (LOG2_DESIGN_SIZE > 0) ? LOG2_DESIGN_SIZE : 1;
    localparam int OFF_W = ADDR_STRIDE_WIDTH + LOG2_DESIGN_SIZE;
    localparam int SUM_W = (AWIDTH > OFF_W) ? AWIDTH : OFF_W;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WAIT_NORM,
        DONE
    } state_t;

    state_t                          state_reg, state_next;
    logic [CW-1:0]                   count_reg, count_next;
    logic [OFF_W-1:0]                off_reg, off_next;
    logic                            ram_en_reg, ram_en_next;
    logic [AWIDTH-1:0]               ram_addr_reg, ram_addr_next;
    logic                            rd_valid_reg;
    logic                            out_valid_reg;
    logic [DESIGN_SIZE*DWIDTH-1:0]   out_data_reg;
    logic [DESIGN_SIZE*DWIDTH-1:0]   padded_data;
    logic [AWIDTH-1:0]               base_reg;
    logic [ADDR_STRIDE_WIDTH-1:0]    stride_reg;
    logic [DWIDTH-1:0]               mean_reg;
    logic [DWIDTH-1:0]               inv_var_reg;
    logic [MASK_WIDTH-1:0]           mask_reg;
    logic                            latch;

    // Next-state and read-issue control. The offset k*stride is accumulated at full width and
    // the sum truncated, so addresses wrap modulo 2^AWIDTH.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        off_next      = off_reg;
        ram_en_next   = 1'b0;
        ram_addr_next = ram_addr_reg;
        latch         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    latch         = 1'b1;
                    state_next    = READ;
                    ram_en_next   = 1'b1;
                    count_next    = '0;
                    off_next      = '0;
                    ram_addr_next = base_addr;
                end
            end
            READ: begin
                if (count_reg == CW'(DESIGN_SIZE - 1)) begin
                    state_next = DRAIN;
                end else begin
                    ram_en_next   = 1'b1;
                    count_next    = count_reg + CW'(1);
                    off_next      = off_reg + OFF_W'(stride_reg);
                    ram_addr_next = AWIDTH'(SUM_W'(base_reg) + SUM_W'(off_next));
                end
            end
            DRAIN: begin
                // Once the read pipeline is empty the last column is on out_data this cycle.
                if (!rd_valid_reg) begin
                    state_next = WAIT_NORM;
                end
            end
            WAIT_NORM: begin
                if (done_norm) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Lane gating applied in front of the output register, so masking adds no latency.
    generate
        for (genvar gi = 0; gi < DESIGN_SIZE; gi++) begin : g_lane
`ifdef NORM_FEEDER_ZERO_PAD_EN
            if (gi < MASK_WIDTH) begin : g_masked
                assign padded_data[gi*DWIDTH +: DWIDTH] =
                    mask_reg[gi] ? ram_rdata[gi*DWIDTH +: DWIDTH] : '0;
            end else begin : g_unmasked
                assign padded_data[gi*DWIDTH +: DWIDTH] = ram_rdata[gi*DWIDTH +: DWIDTH];
            end
`else
            assign padded_data[gi*DWIDTH +: DWIDTH] = ram_rdata[gi*DWIDTH +: DWIDTH];
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            off_reg       <= '0;
            ram_en_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            rd_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            base_reg      <= '0;
            stride_reg    <= '0;
            mean_reg      <= '0;
            inv_var_reg   <= '0;
            mask_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            off_reg       <= off_next;
            ram_en_reg    <= ram_en_next;
            ram_addr_reg  <= ram_addr_next;
            rd_valid_reg  <= ram_en_reg;
            out_valid_reg <= rd_valid_reg;
            out_data_reg  <= padded_data;
            if (latch) begin
                base_reg    <= base_addr;
                stride_reg  <= addr_stride;
                mean_reg    <= mean_in;
                inv_var_reg <= inv_var_in;
                mask_reg    <= mask_in;
            end
        end
    end

    assign ram_en             = ram_en_reg;
    assign ram_addr           = ram_addr_reg;
    assign out_data_available = out_valid_reg;
    assign out_data           = out_data_reg;
    assign mean               = mean_reg;
    assign inv_var            = inv_var_reg;
    assign validity_mask      = mask_reg;
    assign done_feed          = (state_reg == DONE);

endmodule

// File: tb/tb_norm_feeder.sv
// Scoreboard bench for norm_feeder: expected addresses/columns are queued at start, a negedge
// monitor pops and compares whenever ram_en or out_data_available is high.
module tb_norm_feeder;

    localparam int DW = 8;
    localparam int DS = 32;
    localparam int AW = 10;
    localparam int SW = 16;
    localparam int MW = 32;
`ifdef NORM_FEEDER_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [SW-1:0]    addr_stride;
    logic [DW-1:0]    mean_in;
    logic [DW-1:0]    inv_var_in;
    logic [MW-1:0]    mask_in;
    logic             ram_en;
    logic [AW-1:0]    ram_addr;
    logic [DS*DW-1:0] ram_rdata;
    logic             out_data_available;
    logic [DS*DW-1:0] out_data;
    logic [DW-1:0]    mean;
    logic [DW-1:0]    inv_var;
    logic [MW-1:0]    validity_mask;
    logic             done_norm;
    logic             done_feed;

    int tests = 0;
    int fails = 0;
    int ram_mode = 0;
    logic [AW-1:0]    exp_addr_q[$];
    logic [DS*DW-1:0] exp_data_q[$];

    norm_feeder #(
        .DWIDTH(DW), .DESIGN_SIZE(DS), .AWIDTH(AW), .ADDR_STRIDE_WIDTH(SW), .MASK_WIDTH(MW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .addr_stride(addr_stride), .mean_in(mean_in), .inv_var_in(inv_var_in),
        .mask_in(mask_in), .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .out_data_available(out_data_available), .out_data(out_data), .mean(mean),
        .inv_var(inv_var), .validity_mask(validity_mask), .done_norm(done_norm),
        .done_feed(done_feed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode 0: every lane of word a holds a[7:0]. Mode 1: every lane holds 3.0 (0x18).
    function automatic logic [DS*DW-1:0] ram_word(input logic [AW-1:0] a);
        logic [DS*DW-1:0] w;
        for (int i = 0; i < DS; i++) w[i*DW +: DW] = (ram_mode == 1) ? 8'h18 : a[7:0];
        return w;
    endfunction

    function automatic logic [DS*DW-1:0] exp_col(input logic [AW-1:0] a, input logic [MW-1:0] mk);
        logic [DS*DW-1:0] w;
        w = ram_word(a);
        for (int i = 0; i < DS; i++) if (PAD_EN && !mk[i]) w[i*DW +: DW] = '0;
        return w;
    endfunction

    always @(posedge clk) if (ram_en) ram_rdata <= ram_word(ram_addr);

    task automatic check(input string name, input logic [DS*DW-1:0] act, input logic [DS*DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each RAM read and each output column against the queued expectation.
    always @(negedge clk) begin
        if (ram_en === 1'b1) begin
            if (exp_addr_q.size() == 0) check("ram_en_unexpected", 1, 0);
            else check("ram_addr", ram_addr, exp_addr_q.pop_front());
        end
        if (out_data_available === 1'b1) begin
            if (exp_data_q.size() == 0) check("out_valid_unexpected", 1, 0);
            else check("out_data", out_data, exp_data_q.pop_front());
        end
    end

    task automatic run_op(input string name, input logic [AW-1:0] base, input logic [SW-1:0] stride,
                          input int mode, input logic [DW-1:0] mn, input logic [DW-1:0] iv,
                          input logic [MW-1:0] mk, input int done_cyc, input logic [AW-1:0] e2,
                          input logic [AW-1:0] e32, input bit integ, input bit chg5, input int rst_cyc);
        int first_v, nv, ne, first_done, op_bad, x, p;
        logic [AW-1:0] addr2, addr32;
        logic [31:0] s;
        logic [DW-1:0] nrm;
        first_v = 0; nv = 0; ne = 0; first_done = 0; op_bad = 0; addr2 = '0; addr32 = '0;
        ram_mode = mode; base_addr = base; addr_stride = stride;
        mean_in = mn; inv_var_in = iv; mask_in = mk;
        done_norm = (done_cyc == 0);
        for (int k = 0; k < DS; k++) begin
            s = 32'(base) + 32'(k) * 32'(stride);
            exp_addr_q.push_back(s[AW-1:0]);
            exp_data_q.push_back(exp_col(s[AW-1:0], mk));
        end
        start = 1'b1;
        @(posedge clk);  // E0
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (ram_en) ne++;
            if (out_data_available) begin
                nv++;
                if (first_v == 0) first_v = c;
            end
            if (done_feed && first_done == 0) first_done = c;
            if (mean !== mn || inv_var !== iv || validity_mask !== mk) op_bad++;
            if (c == 2) addr2 = ram_addr;
            if (c == 32) addr32 = ram_addr;
            if (integ && c == 3) begin
                x = int'($signed(out_data[DW-1:0]));
                p = (x - int'($signed(mean))) * int'($signed(inv_var));
                nrm = DW'(p >>> 3);
                check({name, "_norm_result"}, nrm, 8'h20);
            end
            if (chg5 && c == 5) begin
                mean_in = ~mn;
                mask_in = ~mk;
            end
            if (rst_cyc != 0 && c == rst_cyc) begin
                reset = 1'b1;
                start = 1'b0;
            end
            if (rst_cyc != 0 && c == rst_cyc + 1) begin
                check({name, "_rst_out_data"}, out_data, 0);
                check({name, "_rst_ctl"}, {ram_en, ram_addr, out_data_available, done_feed,
                                           mean, inv_var, validity_mask}, 0);
                reset = 1'b0;
            end
            if (rst_cyc != 0 && c == rst_cyc + 2) begin
                check({name, "_idle_after_rst"}, {ram_en, out_data_available}, 0);
                exp_addr_q.delete();
                exp_data_q.delete();
                return;
            end
            if (done_cyc != 0) done_norm = (c == done_cyc);
        end
        check({name, "_addr_c2"}, addr2, e2);
        check({name, "_addr_c32"}, addr32, e32);
        check({name, "_first_valid_cycle"}, first_v, 3);
        check({name, "_valid_cycles"}, nv, DS);
        check({name, "_ram_en_cycles"}, ne, DS);
        check({name, "_operand_hold_errs"}, op_bad, 0);
        check({name, "_done_feed_cycle"}, first_done, (done_cyc == 0) ? 36 : done_cyc + 1);
        check({name, "_done_feed_held"}, done_feed, 1);
        start = 1'b0;
        done_norm = 1'b0;
        @(negedge clk);
        check({name, "_done_feed_fall"}, done_feed, 0);
        @(negedge clk);
        check({name, "_no_restart"}, ram_en, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; addr_stride = '0;
        mean_in = 8'h5A; inv_var_in = 8'hA5; mask_in = '1; done_norm = 1'b0; ram_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_data", out_data, 0);
        check("reset_ctl", {ram_en, ram_addr, out_data_available, done_feed,
                            mean, inv_var, validity_mask}, 0);
        reset = 1'b0;
        @(negedge clk);

        run_op("basic", 10'h010, 16'h0001, 0, 8'h11, 8'h22, 32'hFFFF_FFFF, 40,
               10'h011, 10'h02F, 1'b0, 1'b0, 0);
        run_op("wrap", 10'h3F0, 16'h0010, 0, 8'h01, 8'h02, 32'hFFFF_FFFF, 0,
               10'h000, 10'h1E0, 1'b0, 1'b0, 0);
        run_op("integ", 10'h100, 16'h0002, 1, 8'h08, 8'h10, 32'hFFFF_FFFF, 45,
               10'h102, 10'h13E, 1'b1, 1'b0, 0);
        run_op("hold", 10'h020, 16'h0003, 0, 8'h33, 8'h44, 32'hF0F0_1234, 38,
               10'h023, 10'h07D, 1'b0, 1'b1, 0);
        run_op("rst_mid", 10'h010, 16'h0001, 0, 8'h77, 8'h66, 32'hFFFF_FFFF, 50,
               10'h011, 10'h02F, 1'b0, 1'b0, 10);
        run_op("basic_again", 10'h010, 16'h0001, 0, 8'h11, 8'h22, 32'hFFFF_FFFF, 40,
               10'h011, 10'h02F, 1'b0, 1'b0, 0);
        run_op("zero_pad", 10'h010, 16'h0001, 0, 8'h00, 8'h08, 32'h0000_FFFF, 50,
               10'h011, 10'h02F, 1'b0, 1'b0, 0);

        check("queues_drained", exp_addr_q.size() + exp_data_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
